// File: rtl/lbp_hist_pkg.sv
// Shared types and constants for the LBP histogram block: state encoding,
// bin/count widths and the saturating increment used by the bin pipeline.
package lbp_hist_pkg;

    localparam int NUM_BINS = 256;
    localparam int BIN_W    = 8;
    localparam int CNT_W    = 14;

    typedef logic [BIN_W-1:0] bin_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX  = cnt_t'(16383);
    localparam bin_t LAST_BIN = bin_t'(NUM_BINS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == CNT_MAX) ? CNT_MAX : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// Histogram readout stream: one word per bin, valid/ready handshake.
interface lbp_hist_if;
    import lbp_hist_pkg::*;

    logic hist_valid;
    logic hist_ready;
    bin_t hist_bin;
    cnt_t hist_count;

    modport master (output hist_valid, output hist_bin, output hist_count, input hist_ready);
    modport slave  (input hist_valid, input hist_bin, input hist_count, output hist_ready);

endinterface

// File: rtl/lbp_hist_ram.sv
// 256 x 14 bin storage: one synchronous write port, one asynchronous read port.
module lbp_hist_ram
    import lbp_hist_pkg::*;
(
    input  logic clk,
    input  logic we,
    input  bin_t waddr,
    input  cnt_t wdata,
    input  bin_t raddr,
    output cnt_t rdata
);

    cnt_t mem [NUM_BINS];

    // NOTE: storage has no reset; every frame starts with a CLEAR pass, and a
    // reset here would force flops instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lbp_hist.sv
// LBP histogram: clears 256 bins, counts incoming codes through a forwarded
// read-modify-write pipeline, then streams the bins out in order.
module lbp_hist
    import lbp_hist_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        lbp_valid,
    input  bin_t        lbp_data,
    input  logic [13:0] lbp_addr,
    input  logic        finish,
    lbp_hist_if.master  hist,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t state, state_nxt;
    bin_t   ptr, ptr_nxt;
    logic   flush_cnt, flush_cnt_nxt;

    logic   start_ok;
    logic   accept;
    logic   p_valid;
    bin_t   p_bin;
    cnt_t   p_old;
    cnt_t   p_inc;
    cnt_t   cur;
    logic   sat_hit;
    cnt_t   frame_cnt;

    logic   ram_we;
    bin_t   ram_waddr;
    cnt_t   ram_wdata;
    bin_t   ram_raddr;
    cnt_t   ram_rdata;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign accept   = lbp_valid && (state == ST_ACCUM);

    // A code hitting the bin being written this cycle must see the new value.
    assign p_inc   = sat_inc(p_old);
    assign cur     = (p_valid && p_bin == lbp_data) ? p_inc : ram_rdata;
    assign sat_hit = p_valid && (p_old == CNT_MAX);

    assign ram_we    = (state == ST_CLEAR) || p_valid;
    assign ram_waddr = (state == ST_CLEAR) ? ptr : p_bin;
    assign ram_wdata = (state == ST_CLEAR) ? '0 : p_inc;
    assign ram_raddr = (state == ST_DRAIN) ? ptr : lbp_data;

    lbp_hist_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            flush_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement leaves a value held (no latch).
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        flush_cnt_nxt = flush_cnt;
        busy          = 1'b0;
        done          = 1'b0;
        hist.hist_valid = 1'b0;
        hist.hist_bin   = '0;
        hist.hist_count = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (ptr == LAST_BIN) begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                busy = 1'b1;
                if (finish) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = 1'b0;
                end
            end
            ST_FLUSH: begin
                busy          = 1'b1;
                flush_cnt_nxt = 1'b1;
                if (flush_cnt) begin
                    state_nxt = ST_DRAIN;
                    ptr_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                busy            = 1'b1;
                hist.hist_valid = 1'b1;
                hist.hist_bin   = ptr;
                hist.hist_count = ram_rdata;
                if (hist.hist_ready) begin
                    ptr_nxt = ptr + 1'b1;
                    if (ptr == LAST_BIN) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_valid <= 1'b0;
            p_bin   <= '0;
            p_old   <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_bin <= lbp_data;
                p_old <= cur;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (start_ok) begin
            err <= 1'b0;
        end else if ((lbp_valid && state != ST_ACCUM) || sat_hit) begin
            err <= 1'b1;
        end
    end

    // Codes accepted this frame; saturates so it bounds every bin count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (start_ok) begin
            frame_cnt <= '0;
        end else if (accept && frame_cnt != CNT_MAX) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    a_addr_known: assert property (@(posedge clk) disable iff (reset)
        accept |-> !$isunknown(lbp_addr));

    a_bin_bounded: assert property (@(posedge clk) disable iff (reset)
        p_valid |-> (p_inc <= frame_cnt));

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: a bin-count model fed alongside the DUT, and a
// compare process that checks every readout word against it.
module tb_lbp_hist;
    import lbp_hist_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        lbp_valid;
    logic [7:0]  lbp_data;
    logic [13:0] lbp_addr;
    logic        finish;
    logic        busy;
    logic        done;
    logic        err;

    lbp_hist_if hist_bus ();

    lbp_hist dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .lbp_valid (lbp_valid),
        .lbp_data  (lbp_data),
        .lbp_addr  (lbp_addr),
        .finish    (finish),
        .hist      (hist_bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int model_bins [256];
    int dut_bins [256];
    bit model_err;
    int exp_idx;
    int words_seen;
    logic [13:0] addr_cnt = '0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_count(input int c);
        if (model_bins[c] >= 16383) model_err = 1'b1;
        else model_bins[c] = model_bins[c] + 1;
    endtask

    task automatic do_start();
        int b;
        lbp_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model_bins[i] = 0;
            dut_bins[i] = -1;
        end
        model_err  = 1'b0;
        exp_idx    = 0;
        words_seen = 0;
        check("start_err_cleared", int'(err), 0);
        b = 0;
        for (int i = 0; i < 256; i++) begin
            b += int'(busy);
            tick();
        end
        check("clear_busy_cycles", b, 256);
    endtask

    task automatic send_code(input int c);
        lbp_valid = 1'b1;
        lbp_data  = 8'(c);
        lbp_addr  = addr_cnt;
        addr_cnt  = addr_cnt + 1'b1;
        model_count(c);
        tick();
        lbp_valid = 1'b0;
    endtask

    task automatic stray_code(input int c);
        lbp_valid = 1'b1;
        lbp_data  = 8'(c);
        model_err = 1'b1;
        tick();
        lbp_valid = 1'b0;
    endtask

    task automatic do_finish(input bit with_code, input int c);
        finish = 1'b1;
        if (with_code) begin
            lbp_valid = 1'b1;
            lbp_data  = 8'(c);
            model_count(c);
        end
        tick();
        finish    = 1'b0;
        lbp_valid = 1'b0;
        check("flush0_valid", int'(hist_bus.hist_valid), 0);
        tick();
        check("flush1_valid", int'(hist_bus.hist_valid), 0);
        check("flush1_busy", int'(busy), 1);
        tick();
        check("drain_valid", int'(hist_bus.hist_valid), 1);
        check("drain_first_bin", int'(hist_bus.hist_bin), 0);
    endtask

    // mode 0: ready held high; mode 1: ready toggles 1-0-1...
    task automatic do_drain(input int mode);
        int cyc = 0;
        while (!done && cyc < 3000) begin
            hist_bus.hist_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            tick();
            cyc++;
        end
        hist_bus.hist_ready = 1'b0;
        check("drain_in_time", int'(cyc < 3000), 1);
        if (mode == 0) check("drain_cycles", cyc, 256);
        check("drain_words", words_seen, 256);
        check("done_after_drain", int'(done), 1);
        check("busy_after_drain", int'(busy), 0);
        check("valid_after_drain", int'(hist_bus.hist_valid), 0);
        check("err_after_drain", int'(err), int'(model_err));
    endtask

    always @(negedge clk) begin
        if (!reset && hist_bus.hist_valid) begin
            if (exp_idx > 255) begin
                check("word_overrun", exp_idx, 255);
            end else begin
                check("word_bin", int'(hist_bus.hist_bin), exp_idx);
                check("word_count", int'(hist_bus.hist_count), model_bins[exp_idx]);
                dut_bins[hist_bus.hist_bin] = int'(hist_bus.hist_count);
                if (hist_bus.hist_ready) begin
                    exp_idx++;
                    words_seen++;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        lbp_valid = 1'b0;
        lbp_data = '0;
        lbp_addr = '0;
        finish = 1'b0;
        hist_bus.hist_ready = 1'b0;
        #12;
        check("rst_valid", int'(hist_bus.hist_valid), 0);
        check("rst_bin", int'(hist_bus.hist_bin), 0);
        check("rst_count", int'(hist_bus.hist_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        tick();
        reset = 1'b0;
        tick();

        // Stray code in IDLE sets err; the next start clears it.
        stray_code(9);
        check("idle_code_err", int'(err), 1);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("idle_finish_ignored", int'(busy), 0);

        // Empty frame: every bin reads zero.
        do_start();
        do_finish(1'b0, 0);
        do_drain(0);
        check("empty_bin0", dut_bins[0], 0);
        check("empty_bin255", dut_bins[255], 0);

        // Back-to-back identical codes through the forwarding path, toggling ready.
        do_start();
        send_code(5); send_code(5); send_code(5); send_code(7); send_code(5);
        do_finish(1'b0, 0);
        do_drain(1);
        check("fwd_bin5", dut_bins[5], 4);
        check("fwd_bin7", dut_bins[7], 1);
        check("fwd_bin6", dut_bins[6], 0);
        check("fwd_err", int'(err), 0);

        // Code arriving with finish is still counted; codes in DONE only flag err.
        do_start();
        send_code(8'h3C);
        do_finish(1'b1, 8'h3C);
        do_drain(0);
        check("finish_code_bin60", dut_bins[60], 2);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("done_finish_ignored", int'(done), 1);
        stray_code(8'h3C);
        check("done_code_err", int'(err), 1);
        check("done_code_done", int'(done), 1);
        check("done_code_valid", int'(hist_bus.hist_valid), 0);

        // Largest legal count, then saturation.
        do_start();
        for (int i = 0; i < 15876; i++) send_code(8'hFF);
        do_finish(1'b0, 0);
        do_drain(0);
        check("max_legal_bin255", dut_bins[255], 15876);
        check("max_legal_bin254", dut_bins[254], 0);
        check("max_legal_err", int'(err), 0);

        do_start();
        for (int i = 0; i < 15876 + 2508; i++) send_code(8'hFF);
        do_finish(1'b0, 0);
        do_drain(0);
        check("sat_bin255", dut_bins[255], 16383);
        check("sat_err", int'(err), 1);

        // Reset in the middle of the readout, then a fresh frame.
        do_start();
        send_code(100); send_code(100); send_code(3);
        do_finish(1'b0, 0);
        hist_bus.hist_ready = 1'b1;
        cyc = 0;
        while (hist_bus.hist_bin != 8'd100 && cyc < 500) begin
            tick();
            cyc++;
        end
        hist_bus.hist_ready = 1'b0;
        check("reached_bin100", int'(hist_bus.hist_bin), 100);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", int'(hist_bus.hist_valid), 0);
        check("async_rst_bin", int'(hist_bus.hist_bin), 0);
        check("async_rst_busy", int'(busy), 0);
        tick();
        reset = 1'b0;
        check("post_rst_err", int'(err), 0);
        check("post_rst_done", int'(done), 0);
        tick();
        do_start();
        do_finish(1'b0, 0);
        do_drain(0);
        check("reclear_bin100", dut_bins[100], 0);
        check("reclear_bin3", dut_bins[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lbp_hist.md
LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have: clk  in  1  clock, all flops rising-edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high.
REQ-003 SHALL have: start  in  1  one-cycle pulse; clears histogram and begins a new frame.
REQ-004 SHALL have: lbp_valid  in  1  LBP code present this cycle (upstream LBP encoder output).
REQ-005 SHALL have: lbp_data  in  8  LBP code, used as bin index.
REQ-006 SHALL have: lbp_addr  in  14  pixel address of the code; checked only, not stored.
REQ-007 SHALL have: finish  in  1  upstream frame complete; level, sampled.
REQ-008 SHALL have: hist_ready  in  1  consumer accepts readout word.
REQ-009 SHALL have: hist_valid  out  1  readout word valid.
REQ-010 SHALL have: hist_bin  out  8  bin index of readout word.
REQ-011 SHALL have: hist_count  out  14  bin count of readout word.
REQ-012 SHALL have: busy  out  1  high in CLEAR, ACCUM, FLUSH, DRAIN.
REQ-013 SHALL have: done  out  1  high in DONE.
REQ-014 SHALL have: err  out  1  sticky; code received outside ACCUM, or count saturated.

Function
REQ-015 SHALL implement FSM IDLE, CLEAR, ACCUM, FLUSH, DRAIN, DONE; start from IDLE or DONE -> CLEAR; start in any other state ignored.
REQ-016 CLEAR SHALL write 0 to bins 0..255, one per cycle, 256 cycles, then -> ACCUM; clears err.
REQ-017 ACCUM SHALL accept one code per cycle with no back-pressure; each accepted code increments bin[lbp_data] by 1.
REQ-018 Increment SHALL be a 2-stage read-modify-write: cycle N read, cycle N+1 write; the bin update is visible 2 cycles after acceptance.
REQ-019 Same bin in consecutive or overlapping cycles SHALL forward the pending write value; no increment lost (e.g. 3 identical codes back-to-back -> +3).
REQ-020 Counts SHALL saturate at 16383 and set err; max legal count is 15876 (126x126 interior pixels).
REQ-021 SHALL count accepted codes in a 14-bit frame counter; lbp_addr SHALL be treated as informational only.
REQ-022 finish high in ACCUM SHALL -> FLUSH; a code with lbp_valid in the same cycle SHALL still be counted.
REQ-023 FLUSH SHALL last exactly 2 cycles (pipeline empty), then -> DRAIN with bin pointer 0.
REQ-024 DRAIN SHALL present hist_valid=1, hist_bin=pointer, hist_count=bin[pointer]; word held stable while hist_ready=0.
REQ-025 Transfer SHALL occur on hist_valid & hist_ready; pointer +1; after bin 255 transfers -> DONE, hist_valid=0 next cycle.
REQ-026 hist_ready held high SHALL give 256 words in 256 consecutive cycles.
REQ-027 lbp_valid outside ACCUM SHALL be dropped and set err.
REQ-028 DONE SHALL hold until start; finish ignored outside ACCUM.

Reset
REQ-029 reset SHALL force IDLE; hist_valid=0, hist_bin=0, hist_count=0, busy=0, done=0, err=0, pointer=0, pipeline invalid.
REQ-030 Bin storage SHALL NOT require reset; contents undefined until a CLEAR completes.
REQ-031 reset mid-frame SHALL abort immediately; a subsequent start SHALL run a full CLEAR.

Structure
REQ-032 Shared package SHALL hold: state encoding, NUM_BINS=256, CNT_W=14, BIN_W=8, CNT_MAX=16383.
REQ-033 Bin storage SHALL be sub-module lbp_hist_ram: 256x14, one synchronous write port, one read port (async read permitted).
REQ-034 Forwarding, FSM, and readout SHALL reside in lbp_hist.

Verification
REQ-035 reset, start -> busy=1 for 256 CLEAR cycles, then ACCUM; drain with no codes -> 256 words, all hist_count=0, then done=1.
REQ-036 codes 5,5,5,7,5 on consecutive cycles, finish -> bin5=4, bin7=1, all others 0.
REQ-037 15876 codes all 0xFF, finish -> bin255=15876, err=0; a further 2508 codes -> bin255=16383, err=1.
REQ-038 drain with hist_ready toggling 1-0-1 -> word stable while ready=0, no bin skipped or repeated, bins 0..255 in order.
REQ-039 finish with lbp_valid=1 code 0x3C in same cycle -> bin60 includes it; lbp_valid in DONE -> err=1, histogram unchanged.
REQ-040 reset asserted mid-DRAIN at bin 100 -> IDLE, hist_valid=0 asynchronously; new start -> full CLEAR, all bins 0.
